canvas_blitter: RTL

- Read-side engine for the 320x240 canvas RAM; counterpart to the game-state writer.
- On start, scans a rectangle of canvas RAM in raster order and streams pixels to vga_adapter with plot.
- Canvas RAM has a synchronous read with 1-cycle latency. Address = y*320 + x.

---
 rtl/canvas_blitter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/canvas_blitter.sv
// Raster-order read engine: scans a clipped rectangle of the 320x240 canvas RAM and streams
// pixels to the VGA adapter. Define CANVAS_BLITTER_TRANSPARENT_KEY_EN to suppress key-coloured plots.
module canvas_blitter #(
   parameter int CBIT   = 11,
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic [8:0]        x0,
   input  logic [7:0]        y0,
   input  logic [8:0]        width,
   input  logic [7:0]        height,
   input  logic              pause,
   input  logic [CBIT:0]     key_colour,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [CBIT:0]     mem_q,
   output logic [8:0]        vga_x,
   output logic [7:0]        vga_y,
   output logic [CBIT:0]     vga_colour,
   output logic              plot,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [8:0]          cx_q, cx_d, x0_q, x0_d, xl_q, xl_d;
   logic [7:0]          cy_q, cy_d, yl_q, yl_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                s1_v_q, s1_v_d;
   logic [8:0]          s1_x_q, s1_x_d;
   logic [7:0]          s1_y_q, s1_y_d;
   logic                plot_q, plot_d;
   logic [8:0]          vga_x_q, vga_x_d;
   logic [7:0]          vga_y_q, vga_y_d;
   logic [CBIT:0]       vga_colour_q, vga_colour_d;

   logic [8:0]          rem_x, ew;
   logic [7:0]          rem_y, eh;
   logic                empty, issue, hit;

   // y*320 + x as two shifts; exact in ADDR_W bits.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] y, input logic [8:0] x);
      return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
   endfunction

   always_comb begin
      rem_x = 9'(H_RES) - x0;
      rem_y = 8'(V_RES) - y0;
      ew    = (width < rem_x) ? width : rem_x;
      eh    = (height < rem_y) ? height : rem_y;
      empty = (x0 >= 9'(H_RES)) || (y0 >= 8'(V_RES)) || (ew == 9'd0) || (eh == 8'd0);
   end

`ifdef CANVAS_BLITTER_TRANSPARENT_KEY_EN
   assign hit = (mem_q == key_colour);
`else
   logic unused_key;
   assign unused_key = ^key_colour;
   assign hit        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      x0_d    = x0_q;
      xl_d    = xl_q;
      yl_d    = yl_q;
      addr_d  = addr_q;
      issue   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (empty) begin
                  state_d = StDone;
               end else begin
                  state_d = StRun;
                  x0_d    = x0;
                  xl_d    = x0 + ew - 9'd1;
                  yl_d    = y0 + eh - 8'd1;
                  cx_d    = x0;
                  cy_d    = y0;
                  addr_d  = pix_addr(y0, x0);
               end
            end
         end
         StRun: begin
            if (!pause) begin
               issue = 1'b1;
               if (cx_q == xl_q) begin
                  if (cy_q == yl_q) begin
                     state_d = StDrain;
                  end else begin
                     cx_d   = x0_q;
                     cy_d   = cy_q + 8'd1;
                     addr_d = pix_addr(cy_q + 8'd1, x0_q);
                  end
               end else begin
                  cx_d   = cx_q + 9'd1;
                  addr_d = pix_addr(cy_q, cx_q + 9'd1);
               end
            end
         end
         // The last read is in flight while s1_v_q is high; it plots this cycle once that drops.
         StDrain: if (!s1_v_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      s1_v_d       = issue;
      s1_x_d       = issue ? cx_q : s1_x_q;
      s1_y_d       = issue ? cy_q : s1_y_q;
      plot_d       = s1_v_q && !hit;
      vga_x_d      = plot_d ? s1_x_q : vga_x_q;
      vga_y_d      = plot_d ? s1_y_q : vga_y_q;
      vga_colour_d = plot_d ? mem_q  : vga_colour_q;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= StIdle;
         cx_q         <= '0;
         cy_q         <= '0;
         x0_q         <= '0;
         xl_q         <= '0;
         yl_q         <= '0;
         addr_q       <= '0;
         s1_v_q       <= 1'b0;
         s1_x_q       <= '0;
         s1_y_q       <= '0;
         plot_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
      end else begin
         state_q      <= state_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         x0_q         <= x0_d;
         xl_q         <= xl_d;
         yl_q         <= yl_d;
         addr_q       <= addr_d;
         s1_v_q       <= s1_v_d;
         s1_x_q       <= s1_x_d;
         s1_y_q       <= s1_y_d;
         plot_q       <= plot_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
      end
   end

   assign mem_addr   = addr_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign plot       = plot_q;
   assign busy       = (state_q == StRun) || (state_q == StDrain);
   assign done       = (state_q == StDone);

endmodule
